// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Parametrised inter-stage pipeline register with a valid/ready
//            handshake, a 2-entry skid buffer, synchronous flush and
//            control-bit zeroing on bubbles. Parents pack their stage fields
//            into the ctrl and data buses.
// Ports    : clk, rst_n (async, active-low)
//            flush_i                       - drop held and incoming beats
//            in_valid_i / in_ready_o       - upstream handshake (ready is a flop)
//            in_ctrl_i / in_data_i         - upstream control bits / payload
//            out_valid_o / out_ready_i     - downstream handshake (valid is a flop)
//            out_ctrl_o / out_data_o       - control (masked by valid) / payload
//            occupancy_o                   - beats held (0, 1, 2)
//            stall_cnt_o, bubble_cnt_o     - saturating statistics counters,
//                                            present only with PIPE_STAGE_STATS_EN
// Options  : `define PIPE_STAGE_STATS_EN adds the CNT_W parameter and the two
//            counter ports. Without it the block carries no counter logic.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 3
`ifdef PIPE_STAGE_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
`ifdef PIPE_STAGE_STATS_EN
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
`endif
    output logic [1:0]        occupancy_o
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_out_valid;
    logic                r_in_ready;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;

    logic                w_accept;
    logic                w_take;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    assign w_accept = in_valid_i & r_in_ready;
    assign w_take   = r_out_valid & out_ready_i;

    // Next-state and register-load selection. Flush overrides everything,
    // so a beat accepted in the flush cycle is never loaded.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush_i) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = S_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_take) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = S_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_take) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only draining is possible.
                    if (w_take) begin
                        w_state_nxt      = S_ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Handshake flags are registered from the next state so that neither
    // out_valid_o nor in_ready_o has a combinational path from any input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != S_EMPTY);
            r_in_ready  <= (w_state_nxt != S_TWO);
            if (w_load_main_in) begin
                r_main_ctrl <= in_ctrl_i;
                r_main_data <= in_data_i;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= in_ctrl_i;
                r_skid_data <= in_data_i;
            end
        end
    end

    assign out_valid_o = r_out_valid;
    assign in_ready_o  = r_in_ready;
    assign out_data_o  = r_main_data;
    // Bubbles (including post-flush stale payload) never present write enables.
    assign out_ctrl_o  = r_main_ctrl & {CTRL_W{r_out_valid}};
    assign occupancy_o = r_state;

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // Counters ignore flush; only rst_n clears them. Both saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_out_valid && !out_ready_i && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (!r_out_valid && !flush_i && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg. Directed scenarios plus
//            a randomized run against a 2-deep FIFO reference model.
//            Define PIPE_STAGE_STATS_EN to also exercise the counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DATA_W = 8;
    localparam int CTRL_W = 3;
`ifdef PIPE_STAGE_STATS_EN
    localparam int CNT_W  = 3;
`endif

    logic              clk;
    logic              rst_n;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [CTRL_W-1:0] in_ctrl_i;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CTRL_W-1:0] out_ctrl_o;
    logic [DATA_W-1:0] out_data_o;
    logic [1:0]        occupancy_o;
`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  bubble_cnt_o;
`endif

    int total;
    int bad;

    pipe_stage_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush_i(flush_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .in_ctrl_i(in_ctrl_i),
        .in_data_i(in_data_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_ctrl_o(out_ctrl_o),
        .out_data_o(out_data_o),
`ifdef PIPE_STAGE_STATS_EN
        .stall_cnt_o(stall_cnt_o),
        .bubble_cnt_o(bubble_cnt_o),
`endif
        .occupancy_o(occupancy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_ctrl_i = '0; in_data_i = '0;
        #12;
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: actual=%b required=0", out_valid_o); end
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: actual=%b required=1", in_ready_o); end
        total++; if (out_ctrl_o !== 3'b000) begin bad++; $display("FAIL reset_ctrl: actual=%b required=000", out_ctrl_o); end
        total++; if (out_data_o !== 8'h00) begin bad++; $display("FAIL reset_data: actual=%h required=00", out_data_o); end
        total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL reset_occ: actual=%0d required=0", occupancy_o); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        in_valid_i = 1'b1; in_data_i = 8'hA5; in_ctrl_i = 3'b101; out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid: actual=%b required=1", out_valid_o); end
        total++; if (out_data_o !== 8'hA5) begin bad++; $display("FAIL single_data: actual=%h required=a5", out_data_o); end
        total++; if (out_ctrl_o !== 3'b101) begin bad++; $display("FAIL single_ctrl: actual=%b required=101", out_ctrl_o); end
        tick();
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL single_bubble_valid: actual=%b required=0", out_valid_o); end
        total++; if (out_ctrl_o !== 3'b000) begin bad++; $display("FAIL single_bubble_ctrl: actual=%b required=000", out_ctrl_o); end
        total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL single_occ: actual=%0d required=0", occupancy_o); end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] rx[$];
        int src;
        logic hs_in;
        logic hs_out;
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 8'h01; in_ctrl_i = 3'b001;
        tick();
        in_data_i = 8'h02; in_ctrl_i = 3'b010;
        tick();
        total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL bp_ready: actual=%b required=0", in_ready_o); end
        total++; if (occupancy_o !== 2'd2) begin bad++; $display("FAIL bp_occ: actual=%0d required=2", occupancy_o); end
        in_data_i = 8'h03; in_ctrl_i = 3'b011;
        tick();
        total++; if (out_data_o !== 8'h01) begin bad++; $display("FAIL bp_hold_data: actual=%h required=01", out_data_o); end
        total++; if (out_ctrl_o !== 3'b001) begin bad++; $display("FAIL bp_hold_ctrl: actual=%b required=001", out_ctrl_o); end
        total++; if (occupancy_o !== 2'd2) begin bad++; $display("FAIL bp_hold_occ: actual=%0d required=2", occupancy_o); end
        src = 3;
        out_ready_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid_i = (src <= 4);
            in_data_i  = 8'(src);
            in_ctrl_i  = 3'(src);
            hs_in  = in_valid_i & in_ready_o;
            hs_out = out_valid_o & out_ready_i;
            if (hs_out) rx.push_back(out_data_o);
            tick();
            if (hs_in) src++;
        end
        in_valid_i = 1'b0;
        total++; if (rx.size() !== 4) begin bad++; $display("FAIL bp_count: actual=%0d required=4", rx.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < rx.size()) begin
                total++;
                if (rx[i] !== 8'(i + 1)) begin bad++; $display("FAIL bp_order[%0d]: actual=%h required=%h", i, rx[i], 8'(i + 1)); end
            end
        end
    endtask

    task automatic test_stream();
        out_ready_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = 8'h10; in_ctrl_i = 3'b000;
        tick();
        for (int i = 1; i < 16; i++) begin
            total++; if (out_valid_o !== 1'b1 || out_data_o !== 8'(16 + i - 1)) begin
                bad++; $display("FAIL stream_data[%0d]: actual=%b/%h required=1/%h", i, out_valid_o, out_data_o, 8'(16 + i - 1));
            end
            total++; if (occupancy_o !== 2'd1 || in_ready_o !== 1'b1) begin
                bad++; $display("FAIL stream_occ[%0d]: actual=occ%0d rdy%b required=occ1 rdy1", i, occupancy_o, in_ready_o);
            end
            in_data_i = 8'(16 + i);
            in_ctrl_i = 3'(i);
            tick();
        end
        in_valid_i = 1'b0;
        total++; if (out_data_o !== 8'h1F || out_ctrl_o !== 3'b111) begin
            bad++; $display("FAIL stream_last: actual=%h/%b required=1f/111", out_data_o, out_ctrl_o);
        end
        tick();
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL stream_drain: actual=%b required=0", out_valid_o); end
    endtask

    task automatic test_flush();
        // Flush from occupancy 2 with an offered beat.
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 8'h55; in_ctrl_i = 3'b111;
        tick();
        in_data_i = 8'h66;
        tick();
        total++; if (occupancy_o !== 2'd2) begin bad++; $display("FAIL flush2_pre_occ: actual=%0d required=2", occupancy_o); end
        flush_i = 1'b1; in_data_i = 8'h77;
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0;
        total++; if (out_valid_o !== 1'b0 || out_ctrl_o !== 3'b000) begin
            bad++; $display("FAIL flush2_out: actual=%b/%b required=0/000", out_valid_o, out_ctrl_o);
        end
        total++; if (occupancy_o !== 2'd0 || in_ready_o !== 1'b1) begin
            bad++; $display("FAIL flush2_state: actual=occ%0d rdy%b required=occ0 rdy1", occupancy_o, in_ready_o);
        end
        // Flush from occupancy 1 while a beat is actually accepted.
        in_valid_i = 1'b1; in_data_i = 8'h55;
        tick();
        flush_i = 1'b1; in_data_i = 8'h77;
        tick();
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        total++; if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0) begin
            bad++; $display("FAIL flush1_state: actual=occ%0d v%b required=occ0 v0", occupancy_o, out_valid_o);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_leak[%0d]: actual=%b/%h required=0", c, out_valid_o, out_data_o); end
        end
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 8'h11; in_ctrl_i = 3'b001;
        tick();
        in_data_i = 8'h22;
        tick();
        in_valid_i = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin
            bad++; $display("FAIL areset_async: actual=v%b occ%0d required=v0 occ0", out_valid_o, occupancy_o);
        end
        total++; if (out_ctrl_o !== 3'b000 || in_ready_o !== 1'b1) begin
            bad++; $display("FAIL areset_ctrl: actual=%b rdy%b required=000 rdy1", out_ctrl_o, in_ready_o);
        end
        tick();
        rst_n = 1'b1;
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL areset_ready: actual=%b required=1", in_ready_o); end
        in_valid_i = 1'b1; in_data_i = 8'h3C; in_ctrl_i = 3'b011; out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        total++; if (out_valid_o !== 1'b1 || out_data_o !== 8'h3C || out_ctrl_o !== 3'b011) begin
            bad++; $display("FAIL areset_beat: actual=%b/%h/%b required=1/3c/011", out_valid_o, out_data_o, out_ctrl_o);
        end
        tick();
    endtask

    // Reference: the stage behaves as a FIFO of at most two beats; it is
    // ready when holding fewer than two, presents its oldest beat, and a
    // flush empties it without admitting that cycle's input.
    task automatic test_random();
        logic [CTRL_W+DATA_W-1:0] q[$];
        logic              exp_valid;
        logic [CTRL_W-1:0] exp_ctrl;
        logic              acc;
        logic              tk;
        for (int n = 0; n < 600; n++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            in_data_i   = DATA_W'($urandom);
            in_ctrl_i   = CTRL_W'($urandom);
            out_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 24) == 0);
            exp_valid = (q.size() > 0);
            exp_ctrl  = exp_valid ? q[0][CTRL_W+DATA_W-1:DATA_W] : '0;
            total++; if (out_valid_o !== exp_valid) begin bad++; $display("FAIL rand_valid[%0d]: actual=%b required=%b", n, out_valid_o, exp_valid); end
            total++; if (out_ctrl_o !== exp_ctrl) begin bad++; $display("FAIL rand_ctrl[%0d]: actual=%b required=%b", n, out_ctrl_o, exp_ctrl); end
            if (exp_valid) begin
                total++; if (out_data_o !== q[0][DATA_W-1:0]) begin bad++; $display("FAIL rand_data[%0d]: actual=%h required=%h", n, out_data_o, q[0][DATA_W-1:0]); end
            end
            total++; if (occupancy_o !== 2'(q.size())) begin bad++; $display("FAIL rand_occ[%0d]: actual=%0d required=%0d", n, occupancy_o, q.size()); end
            total++; if (in_ready_o !== (q.size() < 2)) begin bad++; $display("FAIL rand_ready[%0d]: actual=%b required=%b", n, in_ready_o, (q.size() < 2)); end
            acc = in_valid_i && (q.size() < 2);
            tk  = exp_valid && out_ready_i;
            tick();
            if (flush_i) begin
                q.delete();
            end else begin
                if (tk) void'(q.pop_front());
                if (acc) q.push_back({in_ctrl_i, in_data_i});
            end
        end
        flush_i = 1'b0; in_valid_i = 1'b0;
    endtask

`ifdef PIPE_STAGE_STATS_EN
    task automatic test_stats();
        #3 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (stall_cnt_o !== 3'd0 || bubble_cnt_o !== 3'd0) begin
            bad++; $display("FAIL stats_reset: actual=%0d/%0d required=0/0", stall_cnt_o, bubble_cnt_o);
        end
        out_ready_i = 1'b0;
        in_valid_i = 1'b1; in_data_i = 8'h5A; in_ctrl_i = 3'b001;
        tick();
        in_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        total++; if (stall_cnt_o !== 3'd5) begin bad++; $display("FAIL stats_stall5: actual=%0d required=5", stall_cnt_o); end
        total++; if (bubble_cnt_o !== 3'd1) begin bad++; $display("FAIL stats_bubble1: actual=%0d required=1", bubble_cnt_o); end
        for (int c = 0; c < 10; c++) tick();
        total++; if (stall_cnt_o !== 3'd7) begin bad++; $display("FAIL stats_sat: actual=%0d required=7", stall_cnt_o); end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        total++; if (stall_cnt_o !== 3'd7) begin bad++; $display("FAIL stats_flush: actual=%0d required=7", stall_cnt_o); end
        tick();
        total++; if (bubble_cnt_o !== 3'd2) begin bad++; $display("FAIL stats_bubble2: actual=%0d required=2", bubble_cnt_o); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_flush();
        test_async_reset();
        test_random();
`ifdef PIPE_STAGE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
